// File: rtl/fp_addsub_normalize_if.sv
// Handshake bundle for the post-add normalization stage: raw sum in, normalized result out.
interface fp_addsub_normalize_if #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W:0]   in_mant;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_mant;
  logic             out_zero;
  logic             out_ovf;
  logic             out_unf;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_addsub_normalize.sv
// Iterative post-add normalizer: one mantissa shift per clock, then a registered
// result with zero/overflow/underflow flags held until the consumer accepts it.
module fp_addsub_normalize #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  fp_addsub_normalize_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [EXP_W-1:0] EXP_MAX  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MAN_W:0]   MAN_ZERO = {(MAN_W+1){1'b0}};
  localparam logic [MAN_W:0]   MAN_SAT  = {1'b0, {MAN_W{1'b1}}};

  state_e             state_q;
  logic               sign_q;
  logic [EXP_W-1:0]   exp_q;
  logic [MAN_W:0]     mant_q;
  logic               zero_q;
  logic               ovf_q;
  logic               unf_q;

  logic               out_valid_q;
  logic               out_sign_q;
  logic [EXP_W-1:0]   out_exp_q;
  logic [MAN_W-1:0]   out_mant_q;
  logic               out_zero_q;
  logic               out_ovf_q;
  logic               out_unf_q;

  // Control FSM, working registers and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= EXP_ZERO;
      mant_q      <= MAN_ZERO;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= EXP_ZERO;
      out_mant_q  <= {MAN_W{1'b0}};
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q  <= bus.in_sign;
            exp_q   <= bus.in_exp;
            mant_q  <= bus.in_mant;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            state_q <= NORM;
          end else begin
            state_q <= IDLE;
          end
        end
        // Guards on exp are evaluated before any increment/decrement so it never wraps.
        NORM: begin
          if (mant_q[MAN_W] && (exp_q == EXP_MAX)) begin
            mant_q  <= MAN_SAT;
            ovf_q   <= 1'b1;
            state_q <= DONE;
          end else if (mant_q[MAN_W]) begin
            mant_q  <= mant_q >> 1;
            exp_q   <= exp_q + EXP_ONE;
          end else if (mant_q == MAN_ZERO) begin
            exp_q   <= EXP_ZERO;
            zero_q  <= 1'b1;
            state_q <= DONE;
          end else if (mant_q[MAN_W-1]) begin
            state_q <= DONE;
          end else if (exp_q == EXP_ZERO) begin
            unf_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            mant_q  <= mant_q << 1;
            exp_q   <= exp_q - EXP_ONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_sign_q  <= sign_q;
            out_exp_q   <= exp_q;
            out_mant_q  <= mant_q[MAN_W-1:0];
            out_zero_q  <= zero_q;
            out_ovf_q   <= ovf_q;
            out_unf_q   <= unf_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q     <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_addsub_normalize.sv
// Directed plus random checks of the normalizer against an arithmetic reference model.
module tb_fp_addsub_normalize;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fp_addsub_normalize_if #(.EXP_W(3), .MAN_W(4)) bus ();

  fp_addsub_normalize #(.EXP_W(3), .MAN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pack(input int s, input int e, input int m,
                              input int z, input int o, input int u);
    return (s << 10) | (e << 7) | (m << 3) | (z << 2) | (o << 1) | u;
  endfunction

  function automatic int observed();
    return pack(int'(bus.out_sign), int'(bus.out_exp), int'(bus.out_mant),
                int'(bus.out_zero), int'(bus.out_ovf), int'(bus.out_unf));
  endfunction

  // Value-level model: result of normalizing e/m and how many shifts it takes.
  function automatic void ref_model(input int e, input int m, output int oe, output int om,
                                    output int oz, output int oo, output int ou, output int lat);
    int shifts;
    shifts = 0;
    oz = 0; oo = 0; ou = 0;
    if (m == 0) begin
      oz = 1; e = 0;
    end else if (m >= 16 && e == 7) begin
      oo = 1; m = 15;
    end else begin
      if (m >= 16) begin
        m = m / 2; e = e + 1; shifts = 1;
      end
      while (m < 8 && e > 0) begin
        m = m * 2; e = e - 1; shifts++;
      end
      if (m < 8) ou = 1;
    end
    oe = e;
    om = m % 16;
    lat = 2 + shifts;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input int s, input int e, input int m, input int hold);
    int oe, om, oz, oo, ou, lat, res, cyc;
    ref_model(e, m, oe, om, oz, oo, ou, lat);
    res = pack(s, oe, om, oz, oo, ou);
    @(negedge clk);
    chk("in_ready_before_accept", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s[0];
    bus.in_exp   = 3'(e);
    bus.in_mant  = 5'(m);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_exp   = 3'($urandom_range(0, 7));
    bus.in_mant  = 5'($urandom_range(0, 31));
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("result", observed(), res);
    chk("in_ready_in_done", int'(bus.in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_result", observed(), res);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("valid_after_accept", int'(bus.out_valid), 0);
    chk("in_ready_after_accept", int'(bus.in_ready), 1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 3'd0;
    bus.in_mant   = 5'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_outputs", observed(), 0);
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);

    // Directed cases, including the flag boundaries.
    run_op(0, 3, 5'b01010, 0);
    run_op(1, 2, 5'b10110, 0);
    run_op(0, 5, 5'b00011, 0);
    run_op(1, 7, 5'b11000, 0);
    run_op(0, 1, 5'b00001, 0);
    run_op(1, 4, 5'b00000, 0);
    run_op(0, 0, 5'b01001, 0);
    run_op(1, 6, 5'b00101, 5);

    // Abort a 3-shift op mid-normalization.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_exp   = 3'd5;
    bus.in_mant  = 5'b00001;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("norm_in_ready", int'(bus.in_ready), 0);
    reset = 1'b1;
    #1;
    chk("midop_reset_outputs", observed(), 0);
    chk("midop_reset_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midop_reset_in_ready", int'(bus.in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale_result", int'(bus.out_valid), 0);
    run_op(0, 5, 5'b00001, 1);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_addsub_normalize.md
Name: fp_addsub_normalize

Overview:
- Post-add normalization stage of the mini-float add/sub datapath. Input format: 3-bit exponent, 4-bit mantissa, explicit leading one at mantissa bit 3.
- Takes the raw 5-bit mantissa sum (bit 4 = carry-out), the common exponent produced by alignment, and the result sign.
- Normalizes iteratively, one shift per clock: right shift on carry, left shift on leading zeros.
- Presents the normalized exponent/mantissa plus zero, overflow and underflow flags on a valid/ready output.

Parameters:
- EXP_W, 3, exponent field width.
- MAN_W, 4, mantissa field width. in_mant is MAN_W+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  common exponent.
- in_mant  in  MAN_W+1  raw mantissa sum, bit MAN_W is carry.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  result sign, passed through.
- out_exp  out  EXP_W  normalized exponent.
- out_mant  out  MAN_W  normalized mantissa.
- out_zero  out  1  result is zero.
- out_ovf  out  1  exponent overflow; result saturated.
- out_unf  out  1  exponent underflow; result left unnormalized.

Behaviour:
- Reset: state=IDLE, working regs and all outputs 0; in_ready=1 after reset deasserts. Reset mid-operation aborts the op and discards its result.

States:
- IDLE: in_ready=1. On in_valid, load sign/exp/mant into working regs, clear flags, go to NORM.
- NORM: one decision per cycle, checked in priority order:
  1. mant[4]=1 and exp=7: exp=7, mant=5'b01111, ovf=1, go to DONE.
  2. mant[4]=1: mant>>=1 (LSB truncated), exp+=1, stay in NORM.
  3. mant=0: exp=0, zero=1, go to DONE.
  4. mant[3]=1: go to DONE.
  5. exp=0: unf=1, go to DONE; mant unchanged.
  6. Otherwise: mant<<=1, exp-=1, stay in NORM.
- DONE: out_valid=1. Outputs are registered and driven from working regs; out_mant = mant[3:0]. Outputs and flags stay stable while out_ready=0. On out_ready, go to IDLE.

Timing and arithmetic:
- in_ready=0 in NORM and DONE. No back-to-back accept from DONE.
- Latency: out_valid rises 2 cycles after the accepting edge for an already-normalized input, plus 1 cycle per shift.
- At most 1 right shift. At most 3 left shifts, bounded by exp reaching 0.
- Exponent arithmetic never wraps: the exp=7 and exp=0 guards are checked before any increment or decrement.
- At most one of out_zero, out_ovf, out_unf is 1. out_zero takes priority over out_unf, because the mant=0 check comes before the exp=0 check.
- out_* values are don't-care when out_valid=0 but must hold their last values; they only change on NORM-to-DONE.

Test Plan:
- exp=3, mant=5'b01010 -> out_exp=3, out_mant=4'b1010, no flags; out_valid 2 cycles after accept.
- exp=2, mant=5'b10110 -> one right shift; out_exp=3, out_mant=4'b1011; latency 3 cycles.
- exp=5, mant=5'b00011 -> two left shifts; out_exp=3, out_mant=4'b1100; latency 4 cycles.
- Boundaries:
  - exp=7, mant=5'b11000 -> out_exp=7, out_mant=4'b1111, out_ovf=1.
  - exp=1, mant=5'b00001 -> out_exp=0, out_mant=4'b0010, out_unf=1.
  - exp=4, mant=0 -> out_zero=1, out_exp=0, out_mant=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0; accepted when out_ready=1, in_ready returns the next cycle.
  - Assert reset during NORM of a 3-shift op: all outputs 0, state IDLE; the next op completes correctly.
